fp32_normalize_pack: RTL and testbench

//  Post-add back end of the single-precision adder: takes the raw 25-bit mantissa sum,

---
 rtl/fp32_normalize_pack.sv | 168 ++++++++++++++++
 tb/tb_fp32_normalize_pack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_normalize_pack.sv
// Post-add back end of the binary32 adder: normalises the raw mantissa sum one bit per
// cycle, rounds (RNE or RTZ) and packs the IEEE-754 result behind valid/ready handshakes.
module fp32_normalize_pack #(
    parameter int unsigned ROUND_MODE = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_SIGN,
    input  logic [7:0]  IN_EXP,
    input  logic [24:0] IN_MANT,
    input  logic        IN_GUARD,
    input  logic        IN_ROUND,
    input  logic        IN_STICKY,
    input  logic        IN_EXCEPTION,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_RESULT,
    output logic        OUT_OVERFLOW,
    output logic        OUT_UNDERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] mant_q, mant_d;
    logic [8:0]  exp_q, exp_d;
    logic        g_q, g_d;
    logic        r_q, r_d;
    logic        s_q, s_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic        round_inc;
    logic [24:0] round_sum;
    logic [8:0]  round_exp;
    logic [22:0] round_frac;

    // mant_q[24] is always clear in ROUND, so the increment cannot overflow 25 bits.
    assign round_inc  = (ROUND_MODE == 0) && g_q && (r_q || s_q || mant_q[0]);
    assign round_sum  = mant_q + {24'd0, round_inc};
    assign round_exp  = exp_q + {8'd0, round_sum[24]};
    assign round_frac = round_sum[24] ? round_sum[23:1] : round_sum[22:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            g_q      <= g_d;
            r_q      <= r_d;
            s_q      <= s_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        g_d      = g_q;
        r_d      = r_q;
        s_d      = s_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        unique case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    sign_d = IN_SIGN;
                    mant_d = IN_MANT;
                    exp_d  = {1'b0, IN_EXP};
                    g_d    = IN_GUARD;
                    r_d    = IN_ROUND;
                    s_d    = IN_STICKY;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (IN_EXCEPTION) begin
                        result_d = {IN_SIGN, 8'hFF, 23'd0};
                        state_d  = S_DONE;
                    end else if ((IN_EXP == 8'd0) ||
                                 ((IN_MANT == 25'd0) && !IN_GUARD && !IN_ROUND && !IN_STICKY)) begin
                        result_d = {IN_SIGN, 31'd0};
                        state_d  = S_DONE;
                    end else if (IN_MANT[24]) begin
                        mant_d  = {1'b0, IN_MANT[24:1]};
                        exp_d   = {1'b0, IN_EXP} + 9'd1;
                        g_d     = IN_MANT[0];
                        r_d     = IN_GUARD;
                        s_d     = IN_ROUND | IN_STICKY;
                        state_d = S_ROUND;
                    end else if (IN_MANT[23]) begin
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (mant_q[23]) begin
                    state_d = S_ROUND;
                end else if (exp_q == 9'd1) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    // Hand off to ROUND on the shift that brings the hidden bit in,
                    // so each shift costs exactly one cycle.
                    mant_d = {mant_q[23:0], g_q};
                    g_d    = r_q;
                    r_d    = 1'b0;
                    exp_d  = exp_q - 9'd1;
                    if (mant_q[22]) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                mant_d  = round_sum[24] ? {1'b0, round_sum[24:1]} : round_sum;
                exp_d   = round_exp;
                state_d = S_DONE;
                if (round_exp >= 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, round_exp[7:0], round_frac};
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign IN_READY      = (state_q == S_IDLE);
    assign OUT_VALID     = (state_q == S_DONE);
    assign OUT_RESULT    = result_q;
    assign OUT_OVERFLOW  = ovf_q;
    assign OUT_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_fp32_normalize_pack.sv
// Bench for fp32_normalize_pack: directed cases plus random operands, with RNE and RTZ
// instances checked against an arithmetic reference model.
module tb_fp32_normalize_pack;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_SIGN;
    logic [7:0]  IN_EXP;
    logic [24:0] IN_MANT;
    logic        IN_GUARD, IN_ROUND, IN_STICKY, IN_EXCEPTION;
    logic        OUT_READY;

    logic        rdy_a, val_a, ovf_a, unf_a;
    logic [31:0] res_a;
    logic        rdy_b, val_b, ovf_b, unf_b;
    logic [31:0] res_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fp32_normalize_pack #(.ROUND_MODE(0)) dut_rne (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy_a),
        .IN_SIGN(IN_SIGN), .IN_EXP(IN_EXP), .IN_MANT(IN_MANT),
        .IN_GUARD(IN_GUARD), .IN_ROUND(IN_ROUND), .IN_STICKY(IN_STICKY),
        .IN_EXCEPTION(IN_EXCEPTION), .OUT_VALID(val_a), .OUT_READY(OUT_READY),
        .OUT_RESULT(res_a), .OUT_OVERFLOW(ovf_a), .OUT_UNDERFLOW(unf_a)
    );

    fp32_normalize_pack #(.ROUND_MODE(1)) dut_rtz (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy_b),
        .IN_SIGN(IN_SIGN), .IN_EXP(IN_EXP), .IN_MANT(IN_MANT),
        .IN_GUARD(IN_GUARD), .IN_ROUND(IN_ROUND), .IN_STICKY(IN_STICKY),
        .IN_EXCEPTION(IN_EXCEPTION), .OUT_VALID(val_b), .OUT_READY(OUT_READY),
        .OUT_RESULT(res_b), .OUT_OVERFLOW(ovf_b), .OUT_UNDERFLOW(unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Treats {mant,g,r} as one integer with a separate sticky bit and walks the value
    // until the hidden-bit position is set, then rounds.
    function automatic void model(input bit mode, input bit sg, input logic [7:0] e_in,
                                  input logic [24:0] m, input bit g, input bit r,
                                  input bit s, input bit exc, output logic [31:0] res,
                                  output bit ovf, output bit unf, output int lat);
        longint unsigned ext, man;
        int unsigned e;
        bit st, gg, rr, inc;
        ovf = 0;
        unf = 0;
        res = '0;
        lat = 1;
        if (exc) begin
            res = {sg, 8'hFF, 23'd0};
            return;
        end
        if (e_in == 0 || (m == 0 && !g && !r && !s)) begin
            res = {sg, 31'd0};
            return;
        end
        ext = (longint'(m) << 2) | (longint'(g) << 1) | longint'(r);
        st  = s;
        e   = e_in;
        lat = 2;
        if (m[24]) begin
            st  = st | r;
            ext = ext >> 1;
            e   = e + 1;
        end else begin
            while (((ext >> 25) & 1) == 0) begin
                if (e == 1) begin
                    res = {sg, 31'd0};
                    unf = 1;
                    return;
                end
                ext = (ext << 1) & 64'h7FF_FFFF;
                e   = e - 1;
                lat = lat + 1;
            end
        end
        man = ext >> 2;
        gg  = ext[1];
        rr  = ext[0];
        inc = (mode == 0) && gg && (rr || st || man[0]);
        man = man + longint'(inc);
        if ((man >> 24) != 0) begin
            man = man >> 1;
            e   = e + 1;
        end
        if (e >= 255) begin
            res = {sg, 8'hFF, 23'd0};
            ovf = 1;
        end else begin
            res = {sg, e[7:0], man[22:0]};
        end
    endfunction

    task automatic drive_random_inputs();
        IN_SIGN      = $urandom_range(0, 1);
        IN_EXP       = 8'($urandom);
        IN_MANT      = 25'($urandom);
        IN_GUARD     = $urandom_range(0, 1);
        IN_ROUND     = $urandom_range(0, 1);
        IN_STICKY    = $urandom_range(0, 1);
        IN_EXCEPTION = $urandom_range(0, 1);
    endtask

    task automatic run_op(input string name, input bit sg, input logic [7:0] e,
                          input logic [24:0] m, input bit g, input bit r, input bit s,
                          input bit exc, input int hold);
        logic [31:0] r0, r1;
        bit o0, u0, o1, u1;
        int l0, l1, edges;
        model(0, sg, e, m, g, r, s, exc, r0, o0, u0, l0);
        model(1, sg, e, m, g, r, s, exc, r1, o1, u1, l1);
        @(negedge CLK);
        check({name, "/in_ready"}, 32'(rdy_a), 32'd1);
        IN_SIGN = sg; IN_EXP = e; IN_MANT = m;
        IN_GUARD = g; IN_ROUND = r; IN_STICKY = s; IN_EXCEPTION = exc;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        edges = 1;
        while (!val_a && edges < 400) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check({name, "/latency"}, 32'(edges), 32'(l0));
        check({name, "/rne_res"}, res_a, r0);
        check({name, "/rne_ovf"}, 32'(ovf_a), 32'(o0));
        check({name, "/rne_unf"}, 32'(unf_a), 32'(u0));
        check({name, "/rtz_valid"}, 32'(val_b), 32'd1);
        check({name, "/rtz_res"}, res_b, r1);
        check({name, "/rtz_ovf"}, 32'(ovf_b), 32'(o1));
        check({name, "/rtz_unf"}, 32'(unf_b), 32'(u1));
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            drive_random_inputs();
            IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
            check({name, "/hold_valid"}, 32'(val_a), 32'd1);
            check({name, "/hold_ready"}, 32'(rdy_a), 32'd0);
            check({name, "/hold_res"}, res_a, r0);
            check({name, "/hold_flags"}, {30'd0, ovf_a, unf_a}, {30'd0, o0, u0});
        end
        @(negedge CLK);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check({name, "/release_valid"}, 32'(val_a), 32'd0);
        check({name, "/release_ready"}, 32'(rdy_a), 32'd1);
    endtask

    initial begin
        logic [7:0]  re;
        logic [24:0] rm;
        RST = 1'b1;
        IN_VALID = 1'b0; IN_SIGN = 1'b0; IN_EXP = '0; IN_MANT = '0;
        IN_GUARD = 1'b0; IN_ROUND = 1'b0; IN_STICKY = 1'b0; IN_EXCEPTION = 1'b0;
        OUT_READY = 1'b0;
        #1;
        check("reset/valid", 32'(val_a), 32'd0);
        check("reset/ready", 32'(rdy_a), 32'd1);
        check("reset/result", res_a, 32'd0);
        check("reset/flags", {30'd0, ovf_a, unf_a}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        run_op("one_plus_one", 0, 8'd127, 25'h1000000, 0, 0, 0, 0, 0);
        run_op("cancel",       0, 8'd130, 25'h0000001, 0, 0, 0, 0, 0);
        run_op("rne_up",       0, 8'd127, 25'h0800001, 1, 0, 0, 0, 0);
        run_op("rne_tie_even", 0, 8'd127, 25'h0800000, 1, 0, 0, 0, 0);
        run_op("overflow",     0, 8'd254, 25'h1FFFFFF, 1, 0, 0, 0, 0);
        run_op("exception",    1, 8'd10,  25'h0812345, 0, 0, 0, 1, 0);
        run_op("underflow",    0, 8'd3,   25'h0000010, 0, 0, 0, 0, 0);
        run_op("zero_exp",     1, 8'd0,   25'h0FFFFFF, 1, 1, 1, 0, 0);
        run_op("zero_mant",    0, 8'd90,  25'h0000000, 0, 0, 0, 0, 0);
        run_op("guard_only",   0, 8'd90,  25'h0000000, 1, 0, 0, 0, 0);
        run_op("backpressure", 1, 8'd100, 25'h0123457, 1, 1, 0, 0, 5);

        @(negedge CLK);
        IN_SIGN = 0; IN_EXP = 8'd130; IN_MANT = 25'h0000001;
        IN_GUARD = 0; IN_ROUND = 0; IN_STICKY = 0; IN_EXCEPTION = 0;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("midreset/busy", 32'(rdy_a), 32'd0);
        RST = 1'b1;
        #1;
        check("midreset/valid", 32'(val_a), 32'd0);
        check("midreset/ready", 32'(rdy_a), 32'd1);
        check("midreset/result", res_a, 32'd0);
        check("midreset/flags", {30'd0, ovf_a, unf_a}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_op("after_reset", 0, 8'd127, 25'h0C00000, 1, 1, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 7))
                0:       re = 8'd0;
                1:       re = 8'($urandom_range(250, 255));
                2:       re = 8'($urandom_range(1, 6));
                default: re = 8'($urandom_range(1, 254));
            endcase
            rm = 25'($urandom) >> $urandom_range(0, 25);
            if ($urandom_range(0, 5) == 0) rm[24] = 1'b1;
            run_op("random", 1'($urandom_range(0, 1)), re, rm,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
